// File: rtl/keypad_controller_if.sv
// Keypad pins and digit-entry outputs of keypad_controller, grouped for the keypad_controller top.
// Handshake: key_valid is a one-cycle strobe with no ready; key is valid in that cycle and holds until the next accept.
interface keypad_controller_if;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        clear;
  logic [31:0] value;
  logic [3:0]  key;
  logic        key_valid;
  logic [1:0]  state;

  modport master (output rows, output clear, input cols, input value, input key, input key_valid, input state);
  modport slave  (input rows, input clear, output cols, output value, output key, output key_valid, output state);
endinterface

// File: rtl/keypad_controller.sv
// 4x4 hex keypad scanner with frame-based debounce, single-key qualification and an 8-digit shift register.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (re-accept every 32 frames while a key stays held).
module keypad_controller #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                reset,
  keypad_controller_if.slave  bus
);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic [3:0]    rows_s1, rows_s2;
  logic [PW-1:0] presc;
  logic [1:0]    col;
  logic          step_tick, frame_end;
  logic [1:0]    hits;
  logic [3:0]    frame_key;
  logic [3:0]    low;
  logic [2:0]    low_cnt, total;
  logic [1:0]    low_row;
  logic [3:0]    cur_code, res_code;
  logic          res_none, res_key;
  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [3:0]    cand, cand_nxt;
  logic          accept, repeat_fire, fire;
  logic [3:0]    key_r;
  logic          kv_r;
  logic [31:0]   value_r;

  function automatic logic [3:0] key_lut(input logic [1:0] c, input logic [1:0] r);
    case ({c, r})
      4'h0: return 4'h1;  4'h1: return 4'h4;  4'h2: return 4'h7;  4'h3: return 4'h0;
      4'h4: return 4'h2;  4'h5: return 4'h5;  4'h6: return 4'h8;  4'h7: return 4'hF;
      4'h8: return 4'h3;  4'h9: return 4'h6;  4'hA: return 4'h9;  4'hB: return 4'hE;
      4'hC: return 4'hA;  4'hD: return 4'hB;  4'hE: return 4'hC;  default: return 4'hD;
    endcase
  endfunction

  assign step_tick = (presc == PW'(SCAN_DIV - 1));
  assign frame_end = step_tick && (col == 2'd3);
  assign low       = ~rows_s2;
  assign low_cnt   = {2'b0, low[0]} + {2'b0, low[1]} + {2'b0, low[2]} + {2'b0, low[3]};
  assign total     = {1'b0, hits} + low_cnt;
  assign cur_code  = key_lut(col, low_row);
  // The single hit of a frame is either in the column being sampled now or was stored earlier.
  assign res_code  = (low_cnt == 3'd1) ? cur_code : frame_key;
  assign res_none  = (total == 3'd0);
  assign res_key   = (total == 3'd1);

  always_comb begin
    low_row = 2'd0;
    if (low[3]) low_row = 2'd3;
    if (low[2]) low_row = 2'd2;
    if (low[1]) low_row = 2'd1;
    if (low[0]) low_row = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_s1   <= 4'hF;
      rows_s2   <= 4'hF;
      presc     <= '0;
      col       <= 2'd0;
      hits      <= 2'd0;
      frame_key <= 4'h0;
    end else begin
      rows_s1 <= bus.rows;
      rows_s2 <= rows_s1;
      presc   <= step_tick ? '0 : presc + PW'(1);
      if (step_tick) begin
        col <= col + 2'd1;
        if (col == 2'd3) hits <= 2'd0;
        else             hits <= (total >= 3'd2) ? 2'd2 : total[1:0];
        if (low_cnt == 3'd1) frame_key <= cur_code;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cand_nxt  = cand;
    accept    = 1'b0;
    if (frame_end) begin
      case (state)
        S_IDLE: if (res_key) begin
          cand_nxt = res_code;
          cnt_nxt  = CW'(1);
          if (CW'(DEBOUNCE) == CW'(1)) begin
            state_nxt = S_HELD;
            accept    = 1'b1;
          end else begin
            state_nxt = S_DEB;
          end
        end
        S_DEB: if (res_key && res_code == cand) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt_nxt == CW'(DEBOUNCE)) begin
            state_nxt = S_HELD;
            accept    = 1'b1;
          end
        end else begin
          state_nxt = S_IDLE;
        end
        S_HELD: if (res_none) begin
          cnt_nxt   = CW'(1);
          state_nxt = (CW'(DEBOUNCE) == CW'(1)) ? S_IDLE : S_REL;
        end
        default: if (res_none) begin
          cnt_nxt = cnt + CW'(1);
          if (cnt_nxt == CW'(DEBOUNCE)) state_nxt = S_IDLE;
        end else begin
          state_nxt = S_HELD;
        end
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  logic [4:0] rep;
  logic       rep_hit;
  assign rep_hit     = frame_end && state == S_HELD && state_nxt == S_HELD && res_key && res_code == cand;
  assign repeat_fire = rep_hit && (rep == 5'd31);

  // Entering HELD or leaving it toward REL restarts the frame count; it wraps to 0 on each repeat.
  always_ff @(posedge clk) begin
    if (reset) rep <= 5'd0;
    else if (frame_end) begin
      if (state != S_HELD || state_nxt != S_HELD) rep <= 5'd0;
      else if (rep_hit) rep <= rep + 5'd1;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

  assign fire = accept | repeat_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      cand    <= 4'h0;
      key_r   <= 4'h0;
      kv_r    <= 1'b0;
      value_r <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cand  <= cand_nxt;
      kv_r  <= fire;
      if (fire) key_r <= res_code;
      if (bus.clear)  value_r <= 32'h0;
      else if (fire)  value_r <= {value_r[27:0], res_code};
    end
  end

  assign bus.cols      = ~(4'b0001 << col);
  assign bus.value     = value_r;
  assign bus.key       = key_r;
  assign bus.key_valid = kv_r;
  assign bus.state     = state;
endmodule

// File: tb/tb_keypad_controller.sv
// Self-checking bench for keypad_controller: directed frame table, reset sequences, and random frames against a model.
module tb_keypad_controller;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int FRAME    = 4 * SCAN_DIV;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  typedef struct {
    logic [15:0] mask;
    int          clr_at;
    int          kv;
    logic [3:0]  key;
    logic [31:0] value;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mask = 16'h0;
  int          errors = 0;
  int          checks = 0;
  vec_t        vecs[$];
  logic [3:0]  kmap [4][4] = '{'{4'h1, 4'h4, 4'h7, 4'h0},
                               '{4'h2, 4'h5, 4'h8, 4'hF},
                               '{4'h3, 4'h6, 4'h9, 4'hE},
                               '{4'hA, 4'hB, 4'hC, 4'hD}};

  keypad_controller_if bus();

  keypad_controller #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    bus.rows = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!bus.cols[c])
        for (int r = 0; r < 4; r++)
          if (mask[kmap[c][r]]) bus.rows[r] = 1'b0;
  end

  function automatic logic [15:0] kb(input int n);
    return 16'(1) << n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- driver tasks (called at a negedge) ----
  task automatic do_reset();
    reset = 1'b1;
    mask = 16'h0;
    bus.clear = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_frame(input logic [15:0] m, input int clr_at, output int pulses);
    mask = m;
    pulses = 0;
    for (int i = 1; i <= FRAME; i++) begin
      bus.clear = (i == clr_at);
      @(negedge clk);
      if (bus.key_valid) pulses++;
    end
    bus.clear = 1'b0;
  endtask

  // ---- reference model: one call per scan frame ----
  bit          m_held;
  int          m_run, m_rep;
  logic [3:0]  m_cand, m_key;
  logic [31:0] m_val;

  task automatic model_reset();
    m_held = 0; m_run = 0; m_rep = 0; m_cand = 0; m_key = 0; m_val = 0;
  endtask

  task automatic model_frame(input logic [15:0] m, input int clr_at, output int kv);
    int   n;
    int   k;
    bit   fire;
    n = $countones(m);
    k = 0;
    for (int i = 15; i >= 0; i--) if (m[i]) k = i;
    fire = 0;
    if (!m_held) begin
      if (n == 1 && m_run > 0 && 4'(k) == m_cand) m_run++;
      else if (n == 1 && m_run == 0) begin m_cand = 4'(k); m_run = 1; end
      else m_run = 0;
      if (m_run == DEBOUNCE) begin fire = 1; m_held = 1; m_run = 0; m_rep = 0; end
    end else begin
      if (n == 0) begin
        m_run++; m_rep = 0;
        if (m_run == DEBOUNCE) begin m_held = 0; m_run = 0; end
      end else if (m_run > 0) begin
        m_run = 0; m_rep = 0;
      end else if (AR && n == 1 && 4'(k) == m_cand) begin
        m_rep++;
        if (m_rep == 32) begin fire = 1; m_rep = 0; end
      end
    end
    if (clr_at > 0 && clr_at < FRAME) m_val = 0;
    if (fire) begin m_key = m_cand; m_val = (m_val << 4) | 32'(m_cand); end
    if (clr_at == FRAME) m_val = 0;
    kv = fire;
  endtask

  task automatic add(input logic [15:0] m, input int clr, input int kv, input logic [3:0] k, input logic [31:0] v);
    vec_t e;
    e.mask = m; e.clr_at = clr; e.kv = kv; e.key = k; e.value = v;
    vecs.push_back(e);
  endtask

  initial begin
    int          p;
    logic [3:0]  k;
    logic [31:0] v;
    int          hold, sel, clr, mkv;
    logic [15:0] rm;

    // ---- directed frame table (SCAN_DIV=4, DEBOUNCE=2) ----
    k = 4'h0; v = 32'h0;
    add(kb(5), 0, 0, k, v); k = 4'h5; v = 32'h5;       // clean press of 5
    add(kb(5), 0, 1, k, v); add(kb(5), 0, 0, k, v);
    add(16'h0, 0, 0, k, v); add(16'h0, 0, 0, k, v);
    add(kb(3), 0, 0, k, v);                              // one-frame bounce of 3
    add(16'h0, 0, 0, k, v); add(16'h0, 0, 0, k, v);
    for (int d = 1; d <= 9; d++) begin
      add(kb(d), 0, 0, k, v);
      k = 4'(d); v = {v[27:0], 4'(d)};
      add(kb(d), 0, 1, k, v); add(16'h0, 0, 0, k, v); add(16'h0, 0, 0, k, v);
    end
    add(16'h0, 0, 0, 4'h9, 32'h23456789);
    v = 32'h23456789;
    for (int i = 0; i < 4; i++) add(kb(1) | kb(5), 0, 0, k, v);  // two keys down
    add(kb(1), 0, 0, k, v); k = 4'h1; v = 32'h34567891;
    add(kb(1), 0, 1, k, v); add(16'h0, 0, 0, k, v); add(16'h0, 0, 0, k, v);
    v = 32'h0; add(16'h0, 5, 0, k, v);                   // clear while idle
    add(kb(1), 0, 0, k, v); v = 32'h1; add(kb(1), 0, 1, k, v); add(16'h0, 0, 0, k, v); add(16'h0, 0, 0, k, v);
    add(kb(2), 0, 0, k, v); k = 4'h2; v = 32'h12; add(kb(2), 0, 1, k, v); add(16'h0, 0, 0, k, v); add(16'h0, 0, 0, k, v);
    add(kb(10), 0, 0, k, v); k = 4'hA; v = 32'h0;        // clear coincident with accept
    add(kb(10), FRAME, 1, k, v);
    for (int h = 1; h <= 38; h++) begin
      if (AR && h == 32) begin v = 32'hA; add(kb(10), 0, 1, k, v); end
      else add(kb(10), 0, 0, k, v);
    end
    add(16'h0, 0, 0, k, v); add(16'h0, 0, 0, k, v);
    add(kb(4), 0, 0, k, v); k = 4'h4; v = {v[27:0], 4'h4};
    add(kb(4), 0, 1, k, v); add(16'h0, 0, 0, k, v); add(16'h0, 0, 0, k, v);

    // ---- reset values and first step tick ----
    bus.clear = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst cols", 32'(bus.cols), 32'hE);
    chk("rst value", bus.value, 32'h0);
    chk("rst key", 32'(bus.key), 32'h0);
    chk("rst key_valid", 32'(bus.key_valid), 32'h0);
    chk("rst state", 32'(bus.state), 32'h0);
    repeat (3) @(negedge clk);
    chk("cols before tick", 32'(bus.cols), 32'hE);
    @(negedge clk);
    chk("cols after tick", 32'(bus.cols), 32'hD);

    // ---- table ----
    @(negedge clk);
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i].mask, vecs[i].clr_at, p);
      chk($sformatf("vec%0d pulses", i), 32'(p), 32'(vecs[i].kv));
      chk($sformatf("vec%0d key", i), 32'(bus.key), 32'(vecs[i].key));
      chk($sformatf("vec%0d value", i), bus.value, vecs[i].value);
    end

    // ---- reset in the middle of debounce ----
    run_frame(kb(7), 0, p);
    chk("deb frame pulses", 32'(p), 32'h0);
    mask = kb(7);
    p = 0;
    repeat (10) begin @(negedge clk); if (bus.key_valid) p++; end
    reset = 1'b1;
    mask = 16'h0;
    repeat (2) begin @(negedge clk); if (bus.key_valid) p++; end
    chk("midreset value", bus.value, 32'h0);
    chk("midreset key", 32'(bus.key), 32'h0);
    chk("midreset cols", 32'(bus.cols), 32'hE);
    chk("midreset state", 32'(bus.state), 32'h0);
    reset = 1'b0;
    for (int f = 0; f < 2; f++) begin
      run_frame(16'h0, 0, mkv);
      p += mkv;
    end
    chk("midreset pulses", 32'(p), 32'h0);

    // ---- random frames against the model ----
    do_reset();
    model_reset();
    for (int f = 0; f < 70; ) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) rm = 16'h0;
      else if (sel < 8) rm = kb($urandom_range(0, 15));
      else rm = kb($urandom_range(0, 7)) | kb($urandom_range(8, 15));
      hold = (sel >= 4 && sel < 8 && $urandom_range(0, 5) == 0) ? 34 : $urandom_range(1, 4);
      for (int h = 0; h < hold && f < 70; h++, f++) begin
        clr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, FRAME) : 0;
        run_frame(rm, clr, p);
        model_frame(rm, clr, mkv);
        chk($sformatf("rnd%0d pulses", f), 32'(p), 32'(mkv));
        chk($sformatf("rnd%0d key", f), 32'(bus.key), 32'(m_key));
        chk($sformatf("rnd%0d value", f), bus.value, m_val);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
